// File: rtl/mode_sequencer.sv
// mode_sequencer: two debounced keys step a 3-bit mode 0..4 with wrap; `MODE_SEQ_AUTO_ADVANCE_EN adds a dwell auto-advance timer
module mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_adv_n,
    input  logic       key_back_n,
    input  logic       hold,
    output logic [2:0] state,
    output logic       state_changed,
    output logic [7:0] changes
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    // index 0 is the advance key, index 1 the back key
    logic [1:0]    meta_q, sync_q, lvl_q, lvl_d, prev_q, press;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [2:0]    state_q, state_d;
    logic          changed_q, changed_d;
    logic [7:0]    changes_q, changes_d;
    logic          adv, back;
`ifdef MODE_SEQ_AUTO_ADVANCE_EN
    localparam int TW = $clog2(AUTO_PERIOD);
    localparam logic [TW-1:0] TMR_MAX = TW'(AUTO_PERIOD - 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          expire;
`endif

    // two-flop synchronizers, released level is 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {key_back_n, key_adv_n};
            sync_q <= meta_q;
        end
    end

    // debouncers: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = '0;
            if (sync_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_MAX) lvl_d[i] = sync_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // debounced levels, their delayed copies and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q  <= 2'b11;
            prev_q <= 2'b11;
            cnt_q  <= '{default: '0};
        end else begin
            lvl_q  <= lvl_d;
            prev_q <= lvl_q;
            cnt_q  <= cnt_d;
        end
    end

    assign press = prev_q & ~lvl_q;

    // mode stepping: hold discards events, simultaneous events cancel
    always_comb begin
        adv  = press[0];
        back = press[1];
`ifdef MODE_SEQ_AUTO_ADVANCE_EN
        expire = timer_q == TMR_MAX;
        adv    = press[0] | (expire & ~|press);
`endif
        state_d = state_q;
        if (!hold && adv && !back) state_d = (state_q == 3'd4) ? 3'd0 : state_q + 3'd1;
        else if (!hold && back && !adv) state_d = (state_q == 3'd0) ? 3'd4 : state_q - 3'd1;
        changed_d = state_d != state_q;
        changes_d = changes_q + {7'd0, changed_d};
`ifdef MODE_SEQ_AUTO_ADVANCE_EN
        timer_d = (hold || changed_d || expire || |press) ? '0 : timer_q + 1'b1;
`endif
    end

    // mode register, change pulse and change counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= 3'd0;
            changed_q <= 1'b0;
            changes_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            changed_q <= changed_d;
            changes_q <= changes_d;
        end
    end

`ifdef MODE_SEQ_AUTO_ADVANCE_EN
    // dwell timer for auto-advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) timer_q <= '0;
        else timer_q <= timer_d;
    end
`endif

    assign state         = state_q;
    assign state_changed = changed_q;
    assign changes       = changes_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed bench for mode_sequencer with DEBOUNCE_CYCLES=4, AUTO_PERIOD=20
module tb_mode_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_adv_n = 1'b1;
    logic       key_back_n = 1'b1;
    logic       hold = 1'b0;
    logic [2:0] state;
    logic       state_changed;
    logic [7:0] changes;
    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses;

    mode_sequencer #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(20)) dut (
        .clk(clk), .reset_n(reset_n), .key_adv_n(key_adv_n), .key_back_n(key_back_n),
        .hold(hold), .state(state), .state_changed(state_changed), .changes(changes)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // hold the selected keys low 10 cycles then release 8 cycles, counting change pulses
    task automatic press_keys(input logic a, input logic b);
        pulses = 0;
        key_adv_n  = !a;
        key_back_n = !b;
        repeat (10) begin
            @(negedge clk);
            if (state_changed) pulses++;
        end
        key_adv_n  = 1'b1;
        key_back_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (state_changed) pulses++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (state !== 3'd0 || state_changed !== 1'b0 || changes !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values state=%0d chg=%0b changes=%0d exp 0/0/0", state, state_changed, changes);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (state !== 3'd0 || changes !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idle state=%0d changes=%0d exp 0/0", state, changes);
        end
    endtask

    task automatic test_clean_advance();
        logic [2:0] exp_s [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        key_adv_n = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL adv_e5 state=%0d exp 0", state);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || state_changed !== 1'b1 || changes !== 8'd1) begin
            n_fail++;
            $display("FAIL adv_e6 state=%0d chg=%0b changes=%0d exp 1/1/1", state, state_changed, changes);
        end
        @(negedge clk);
        n_checks++;
        if (state_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL adv_pulse_len chg=%0b exp 0", state_changed);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || changes !== 8'd1) begin
            n_fail++;
            $display("FAIL adv_held state=%0d changes=%0d exp 1/1", state, changes);
        end
        key_adv_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            press_keys(1'b1, 1'b0);
            n_checks++;
            if (state !== exp_s[i] || pulses != 1) begin
                n_fail++;
                $display("FAIL adv_seq%0d state=%0d pulses=%0d exp %0d/1", i, state, pulses, exp_s[i]);
            end
        end
        n_checks++;
        if (changes !== 8'd5) begin
            n_fail++;
            $display("FAIL adv_count changes=%0d exp 5", changes);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        pulses = 0;
        repeat (5) begin
            key_adv_n = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (state_changed) pulses++;
            end
            key_adv_n = 1'b1;
            @(negedge clk);
            if (state_changed) pulses++;
        end
        repeat (8) begin
            @(negedge clk);
            if (state_changed) pulses++;
        end
        n_checks++;
        if (state !== 3'd0 || changes !== 8'd0 || pulses != 0) begin
            n_fail++;
            $display("FAIL bounce state=%0d changes=%0d pulses=%0d exp 0/0/0", state, changes, pulses);
        end
    endtask

    task automatic test_back_and_simultaneous();
        do_reset();
        press_keys(1'b0, 1'b1);
        n_checks++;
        if (state !== 3'd4 || changes !== 8'd1 || pulses != 1) begin
            n_fail++;
            $display("FAIL back_wrap state=%0d changes=%0d pulses=%0d exp 4/1/1", state, changes, pulses);
        end
        press_keys(1'b0, 1'b1);
        n_checks++;
        if (state !== 3'd3 || changes !== 8'd2) begin
            n_fail++;
            $display("FAIL back_step state=%0d changes=%0d exp 3/2", state, changes);
        end
        press_keys(1'b1, 1'b1);
        n_checks++;
        if (state !== 3'd3 || changes !== 8'd2 || pulses != 0) begin
            n_fail++;
            $display("FAIL simultaneous state=%0d changes=%0d pulses=%0d exp 3/2/0", state, changes, pulses);
        end
    endtask

    task automatic test_hold();
        do_reset();
        press_keys(1'b1, 1'b0);
        press_keys(1'b1, 1'b0);
        hold = 1'b1;
        press_keys(1'b1, 1'b0);
        n_checks++;
        if (state !== 3'd2 || pulses != 0) begin
            n_fail++;
            $display("FAIL hold_frozen state=%0d pulses=%0d exp 2/0", state, pulses);
        end
        hold = 1'b0;
        press_keys(1'b0, 1'b0);
        n_checks++;
        if (state !== 3'd2 || changes !== 8'd2 || pulses != 0) begin
            n_fail++;
            $display("FAIL hold_no_replay state=%0d changes=%0d pulses=%0d exp 2/2/0", state, changes, pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        for (int i = 0; i < 7; i++) press_keys(seq[i][0], seq[i][1]);
        n_checks++;
        if (state !== 3'd3 || changes !== 8'd7) begin
            n_fail++;
            $display("FAIL pre_reset state=%0d changes=%0d exp 3/7", state, changes);
        end
        key_adv_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || changes !== 8'd0 || state_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset state=%0d changes=%0d chg=%0b exp 0/0/0", state, changes, state_changed);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL held_e5 state=%0d exp 0", state);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || state_changed !== 1'b1 || changes !== 8'd1) begin
            n_fail++;
            $display("FAIL held_e6 state=%0d chg=%0b changes=%0d exp 1/1/1", state, state_changed, changes);
        end
        key_adv_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

`ifdef MODE_SEQ_AUTO_ADVANCE_EN
    task automatic test_auto();
        logic [2:0] exp_s [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            repeat (19) @(negedge clk);
            n_checks++;
            if (state !== ((i == 0) ? 3'd0 : exp_s[i-1])) begin
                n_fail++;
                $display("FAIL auto_pre%0d state=%0d", i, state);
            end
            @(negedge clk);
            n_checks++;
            if (state !== exp_s[i] || state_changed !== 1'b1) begin
                n_fail++;
                $display("FAIL auto_step%0d state=%0d chg=%0b exp %0d/1", i, state, state_changed, exp_s[i]);
            end
        end
        hold = 1'b1;
        repeat (45) @(negedge clk);
        n_checks++;
        if (state !== 3'd0 || changes !== 8'd5) begin
            n_fail++;
            $display("FAIL auto_hold state=%0d changes=%0d exp 0/5", state, changes);
        end
        hold = 1'b0;
        repeat (13) @(negedge clk);
        key_adv_n = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL auto_key_e18 state=%0d exp 0", state);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || changes !== 8'd6) begin
            n_fail++;
            $display("FAIL auto_key_e19 state=%0d changes=%0d exp 1/6", state, changes);
        end
        key_adv_n = 1'b1;
        repeat (19) @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || changes !== 8'd6) begin
            n_fail++;
            $display("FAIL auto_restart state=%0d changes=%0d exp 1/6", state, changes);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL auto_after state=%0d exp 2", state);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MODE_SEQ_AUTO_ADVANCE_EN
        test_auto();
`else
        test_clean_advance();
        test_bounce();
        test_back_and_simultaneous();
        test_hold();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
